// File: rtl/psx_host_poller.sv
// psx_host_poller: console-side master for the PSX controller serial link.
// Runs one 01 42 00 00 00 poll and returns the ID and button bytes.
module psx_host_poller #(
  parameter int CLK_DIV     = 8,
  parameter int ATT_SETUP   = 16,
  parameter int ACK_TIMEOUT = 512,
  parameter int BYTE_GAP    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        data,
  input  logic        ack,
  output logic        psx_clk,
  output logic        att,
  output logic        cmd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  id_byte,
  output logic [15:0] buttons
);

  localparam int M1   = (CLK_DIV > ATT_SETUP) ? CLK_DIV : ATT_SETUP;
  localparam int M2   = (ACK_TIMEOUT > BYTE_GAP) ? ACK_TIMEOUT : BYTE_GAP;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DIV_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_END = CW'(ATT_SETUP - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0] TO_END    = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] DIV_CNT   = CW'(CLK_DIV);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_LOW,
    CLK_HIGH,
    ACK_WAIT,
    ACK_RELEASE,
    GAP,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    b3_q, b3_d;
  logic [7:0]    id_rx_q, id_rx_d;
  logic          psx_clk_q, psx_clk_d;
  logic          att_q, att_d;
  logic          cmd_q, cmd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [7:0]    id_q, id_d;
  logic [15:0]   btn_q, btn_d;
  logic          data_m_q, data_s_q;
  logic          ack_m_q, ack_s_q;
  logic          abort;
  logic [1:0]    abort_code;

  function automatic logic cmd_bit(
    input logic [2:0] b,
    input logic [2:0] i
  );
    logic [7:0] v;
    unique case (b)
      3'd0:    v = 8'h01;
      3'd1:    v = 8'h42;
      default: v = 8'h00;
    endcase
    return v[i];
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    sh_d       = sh_q;
    b3_d       = b3_q;
    id_rx_d    = id_rx_q;
    psx_clk_d  = psx_clk_q;
    att_d      = att_q;
    cmd_d      = cmd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    id_d       = id_q;
    btn_d      = btn_q;
    abort      = 1'b0;
    abort_code = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          att_d   = 1'b0;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
          cnt_d   = '0;
          code_d  = 2'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_END) begin
          cnt_d     = '0;
          psx_clk_d = 1'b0;
          cmd_d     = cmd_bit(byte_q, bit_q);
          state_d   = CLK_LOW;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      CLK_LOW: begin
        if (cnt_q == DIV_END) begin
          cnt_d     = '0;
          psx_clk_d = 1'b1;
          sh_d      = {data_s_q, sh_q[7:1]};
          state_d   = CLK_HIGH;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      CLK_HIGH: begin
        if (cnt_q != DIV_END) begin
          cnt_d = cnt_q + ONE;
        end else if (bit_q != 3'd7) begin
          cnt_d     = '0;
          bit_d     = bit_q + 3'd1;
          psx_clk_d = 1'b0;
          cmd_d     = cmd_bit(byte_q, bit_q + 3'd1);
          state_d   = CLK_LOW;
        end else begin
          // Ack timeout is measured from the 8th rise, so carry the high phase.
          bit_d  = 3'd0;
          byte_d = byte_q + 3'd1;
          cmd_d  = 1'b1;
          cnt_d  = DIV_CNT;
          if (byte_q == 3'd1) id_rx_d = sh_q;
          if (byte_q == 3'd3) b3_d = sh_q;
          if (byte_q == 3'd4) begin
            cnt_d   = '0;
            att_d   = 1'b1;
            done_d  = 1'b1;
            btn_d   = {sh_q, b3_q};
            id_d    = id_rx_q;
            state_d = FINISH;
          end else if (byte_q == 3'd1 && sh_q != 8'h41) begin
            id_d       = sh_q;
            abort      = 1'b1;
            abort_code = 2'd2;
          end else begin
            state_d = ACK_WAIT;
          end
        end
      end
      ACK_WAIT: begin
        if (!ack_s_q) begin
          cnt_d   = cnt_q + ONE;
          state_d = ACK_RELEASE;
        end else if (cnt_q >= TO_END) begin
          abort      = 1'b1;
          abort_code = 2'd1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ACK_RELEASE: begin
        if (ack_s_q) begin
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q >= TO_END) begin
          abort      = 1'b1;
          abort_code = 2'd1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d     = '0;
          psx_clk_d = 1'b0;
          cmd_d     = cmd_bit(byte_q, 3'd0);
          state_d   = CLK_LOW;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      FINISH: begin
        if (cnt_q == SETUP_END) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase

    if (abort) begin
      att_d     = 1'b1;
      psx_clk_d = 1'b1;
      cmd_d     = 1'b1;
      err_d     = 1'b1;
      code_d    = abort_code;
      cnt_d     = '0;
      state_d   = FINISH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      byte_q    <= 3'd0;
      sh_q      <= 8'h00;
      b3_q      <= 8'hFF;
      id_rx_q   <= 8'h00;
      psx_clk_q <= 1'b1;
      att_q     <= 1'b1;
      cmd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
      id_q      <= 8'h00;
      btn_q     <= 16'hFFFF;
      data_m_q  <= 1'b1;
      data_s_q  <= 1'b1;
      ack_m_q   <= 1'b1;
      ack_s_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sh_q      <= sh_d;
      b3_q      <= b3_d;
      id_rx_q   <= id_rx_d;
      psx_clk_q <= psx_clk_d;
      att_q     <= att_d;
      cmd_q     <= cmd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
      id_q      <= id_d;
      btn_q     <= btn_d;
      data_m_q  <= data;
      data_s_q  <= data_m_q;
      ack_m_q   <= ack;
      ack_s_q   <= ack_m_q;
    end
  end

  assign psx_clk  = psx_clk_q;
  assign att      = att_q;
  assign cmd      = cmd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign id_byte  = id_q;
  assign buttons  = btn_q;

endmodule
